// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, PC redirect
// from execute, and the instruction handoff to decode.
interface busca_instrucao_if #(
    parameter int BITSPC    = 64,
    parameter int BITSINSTR = 32
);
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [BITSPC-1:0]    mem_req_addr;
    logic                 mem_resp_valid;
    logic [BITSINSTR-1:0] mem_resp_data;
    logic                 redirect;
    logic [BITSPC-1:0]    redirect_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [BITSINSTR-1:0] instr;
    logic [BITSPC-1:0]    instr_pc;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/busca_instrucao.sv
// RV64 instruction fetch: owns the PC, keeps up to DEPTH reads in flight and
// queues returned words with their PC; redirects flush and drop stale replies.
module busca_instrucao #(
    parameter int                BITSPC    = 64,
    parameter int                BITSINSTR = 32,
    parameter logic [BITSPC-1:0] RESET_PC  = '0,
    parameter int                DEPTH     = 2
) (
    input logic               clk,
    input logic               rst_n,
    busca_instrucao_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {INICIO, BUSCA, DESCARTE} estado_t;

    typedef struct packed {
        logic [BITSINSTR-1:0] instr;
        logic [BITSPC-1:0]    pc;
    } entrada_t;

    estado_t                      estado;
    logic [BITSPC-1:0]            pc;
    logic [CW-1:0]                count, pend, stale;
    logic [CW-1:0]                pend_nxt, stale_nxt;
    logic [CW:0]                  occ;
    entrada_t [DEPTH-1:0]         fila;
    logic [DEPTH-1:0][BITSPC-1:0] fila_end;
    logic [PW-1:0]                q_wr, q_rd, a_wr, a_rd;
    logic                         req_fire, resp, enq, pop;
    logic                         unused_bits;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign occ      = {1'b0, count} + {1'b0, pend};
    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign resp     = bus.mem_resp_valid;
    assign enq      = resp && (stale == '0) && !bus.redirect;
    assign pop      = bus.instr_valid && bus.instr_ready;

    // Counting in-flight requests together with queued ones guarantees a slot
    // for every response, so the queue never needs to push back on memory.
    assign bus.mem_req_valid = (estado == BUSCA) && !bus.redirect && (occ < DEPTH_W);
    assign bus.mem_req_addr  = pc;
    assign bus.instr_valid   = (count != '0) && !bus.redirect;
    assign bus.instr         = fila[q_rd].instr;
    assign bus.instr_pc      = fila[q_rd].pc;
    assign unused_bits       = ^bus.redirect_pc[1:0];

    // A redirect turns whatever is still outstanding after this cycle's
    // response into stale traffic; no request is issued on that cycle.
    always_comb begin
        pend_nxt  = pend + CW'(req_fire) - CW'(resp);
        stale_nxt = stale;
        if (bus.redirect)
            stale_nxt = pend_nxt;
        else if (resp && (stale != '0))
            stale_nxt = stale - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= INICIO;
            pc       <= RESET_PC;
            count    <= '0;
            pend     <= '0;
            stale    <= '0;
            fila     <= '0;
            fila_end <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            a_wr     <= '0;
            a_rd     <= '0;
        end else begin
            pend   <= pend_nxt;
            stale  <= stale_nxt;
            estado <= (stale_nxt != '0) ? DESCARTE : BUSCA;

            // The address FIFO tracks every outstanding request, stale or not,
            // so it stays aligned with the in-order response stream.
            if (req_fire) begin
                fila_end[a_wr] <= pc;
                a_wr           <= inc(a_wr);
            end
            if (resp)
                a_rd <= inc(a_rd);

            if (bus.redirect) begin
                pc    <= {bus.redirect_pc[BITSPC-1:2], 2'b00};
                count <= '0;
                q_wr  <= '0;
                q_rd  <= '0;
            end else begin
                if (req_fire)
                    pc <= pc + BITSPC'(4);
                if (enq) begin
                    fila[q_wr].instr <= bus.mem_resp_data;
                    fila[q_wr].pc    <= fila_end[a_rd];
                    q_wr             <= inc(q_wr);
                end
                if (pop)
                    q_rd <= inc(q_rd);
                count <= count + CW'(enq) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: cycle-by-cycle vector table plus a
// streaming memory model and an asynchronous mid-transfer reset sequence.
module tb_busca_instrucao;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    busca_instrucao_if #(.BITSPC(64), .BITSINSTR(32)) bus ();

    busca_instrucao #(.BITSPC(64), .BITSINSTR(32), .RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [63:0] rpc;
        logic        irdy;
        logic        qv;
        logic [63:0] qa;
        logic        iv;
        logic        ck;
        logic [31:0] ins;
        logic [63:0] ipc;
    } vec_t;

    vec_t vt[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic vec_t v(logic rdy, logic rv, logic [31:0] rd, logic redir, logic [63:0] rpc,
                               logic irdy, logic qv, logic [63:0] qa, logic iv, logic ck,
                               logic [31:0] ins, logic [63:0] ipc);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rd = rd; r.redir = redir; r.rpc = rpc; r.irdy = irdy;
        r.qv = qv; r.qa = qa; r.iv = iv; r.ck = ck; r.ins = ins; r.ipc = ipc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'h0);
        chk({tag, "_req_addr"},  bus.mem_req_addr,        64'h0);
        chk({tag, "_instr_valid"}, 64'(bus.instr_valid),  64'h0);
        chk({tag, "_instr"},     64'(bus.instr),          64'h0);
        chk({tag, "_instr_pc"},  bus.instr_pc,            64'h0);
    endtask

    // Leaves reset released just after a falling edge; the DUT is in INICIO.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_cleared("reset");
        rst_n = 1'b1;
    endtask

    task automatic step(input string tag, input vec_t t);
        bus.mem_req_ready  = t.rdy;
        bus.mem_resp_valid = t.rv;
        bus.mem_resp_data  = t.rd;
        bus.redirect       = t.redir;
        bus.redirect_pc    = t.rpc;
        bus.instr_ready    = t.irdy;
        #1;
        chk({tag, "_req_valid"},   64'(bus.mem_req_valid), 64'(t.qv));
        if (t.qv)
            chk({tag, "_req_addr"}, bus.mem_req_addr, t.qa);
        chk({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'(t.iv));
        if (t.ck) begin
            chk({tag, "_instr"},    64'(bus.instr), 64'(t.ins));
            chk({tag, "_instr_pc"}, bus.instr_pc,   t.ipc);
        end
        @(negedge clk);
    endtask

    initial begin
        logic        mv;
        logic [63:0] ma, exp_req, exp_i;
        int          got;

        n_chk  = 0;
        n_fail = 0;
        idle();
        rst_n = 1'b0;

        //    rdy rv  rd            rdr rpc                    irdy qv qa                     iv ck ins           ipc
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 0,64'h0,                 0,1,32'h0,        64'h0));   // INICIO
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'h0,                 0,0,32'h0,        64'h0));
        vt.push_back(v(1,1,32'h11111111, 0,64'h0,                1, 1,64'h4,                 0,0,32'h0,        64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                0, 0,64'h8,                 1,1,32'h11111111, 64'h0));   // backpressure
        vt.push_back(v(1,1,32'h22222222, 0,64'h0,                0, 0,64'h8,                 1,1,32'h11111111, 64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                0, 0,64'h8,                 1,1,32'h11111111, 64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 0,64'h8,                 1,1,32'h11111111, 64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'h8,                 1,1,32'h22222222, 64'h4));   // resumes at 0x8
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'hC,                 0,0,32'h0,        64'h0));
        vt.push_back(v(1,0,32'h0,        1,64'h103,              1, 0,64'h10,                0,0,32'h0,        64'h0));   // redirect, 2 in flight
        vt.push_back(v(1,1,32'hDEAD0008, 0,64'h0,                1, 0,64'h100,               0,0,32'h0,        64'h0));
        vt.push_back(v(1,1,32'hDEAD000C, 0,64'h0,                1, 0,64'h100,               0,0,32'h0,        64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'h100,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,1,32'h33333333, 0,64'h0,                1, 1,64'h104,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,0,32'h0,        0,64'h0,                0, 1,64'h104,               1,1,32'h33333333, 64'h100));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                0, 1,64'h104,               1,1,32'h33333333, 64'h100));
        vt.push_back(v(1,1,32'h44444444, 1,64'h200,              1, 0,64'h108,               0,0,32'h0,        64'h0));   // redirect+resp+ready
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'h200,               0,0,32'h0,        64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'h204,               0,0,32'h0,        64'h0));
        vt.push_back(v(1,1,32'h55555555, 1,64'h300,              1, 0,64'h208,               0,0,32'h0,        64'h0));   // stale = pend-1 = 1
        vt.push_back(v(1,1,32'h66666666, 0,64'h0,                1, 0,64'h300,               0,0,32'h0,        64'h0));
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'h300,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,1,32'h77777777, 0,64'h0,                1, 1,64'h304,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,0,32'h0,        0,64'h0,                1, 1,64'h304,               1,1,32'h77777777, 64'h300));
        vt.push_back(v(0,0,32'h0,        0,64'h0,                1, 1,64'h304,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,0,32'h0,        1,64'h400,              1, 0,64'h304,               0,0,32'h0,        64'h0));   // back-to-back redirects
        vt.push_back(v(0,0,32'h0,        1,64'h50E,              1, 0,64'h400,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,0,32'h0,        0,64'h0,                1, 1,64'h50C,               0,0,32'h0,        64'h0));
        vt.push_back(v(0,0,32'h0,        1,64'hFFFFFFFFFFFFFFFF, 1, 0,64'h50C,               0,0,32'h0,        64'h0));   // PC wrap
        vt.push_back(v(1,0,32'h0,        0,64'h0,                1, 1,64'hFFFFFFFFFFFFFFFC,  0,0,32'h0,        64'h0));
        vt.push_back(v(0,1,32'h88888888, 0,64'h0,                0, 1,64'h0,                 0,0,32'h0,        64'h0));
        vt.push_back(v(0,0,32'h0,        0,64'h0,                0, 1,64'h0,                 1,1,32'h88888888, 64'hFFFFFFFFFFFFFFFC));

        do_reset();
        foreach (vt[i]) step($sformatf("vec%0d", i), vt[i]);

        // Streaming with a 1-cycle memory returning PC ^ 0xA5A5.
        do_reset();
        mv = 1'b0; ma = '0; exp_req = '0; exp_i = '0; got = 0;
        for (int cyc = 0; cyc < 80 && got < 12; cyc++) begin
            bus.mem_req_ready  = 1'b1;
            bus.instr_ready    = 1'b1;
            bus.redirect       = 1'b0;
            bus.mem_resp_valid = mv;
            bus.mem_resp_data  = ma[31:0] ^ 32'h0000A5A5;
            #1;
            if (bus.mem_req_valid) begin
                chk("stream_req_addr", bus.mem_req_addr, exp_req);
                exp_req += 64'd4;
            end
            mv = bus.mem_req_valid;
            ma = bus.mem_req_addr;
            if (bus.instr_valid) begin
                chk("stream_instr_pc", bus.instr_pc, exp_i);
                chk("stream_instr", 64'(bus.instr), 64'(exp_i[31:0] ^ 32'h0000A5A5));
                exp_i += 64'd4;
                got++;
            end
            @(negedge clk);
        end
        chk("stream_count", 64'(got), 64'd12);

        // Asynchronous reset while a request is held waiting for ready.
        do_reset();
        step("mid0", v(0,0,32'h0,        0,64'h0,1, 0,64'h0, 0,0,32'h0,        64'h0));
        step("mid1", v(1,0,32'h0,        0,64'h0,0, 1,64'h0, 0,0,32'h0,        64'h0));
        step("mid2", v(0,1,32'hAAAA5555, 0,64'h0,0, 1,64'h4, 0,0,32'h0,        64'h0));
        step("mid3", v(0,0,32'h0,        0,64'h0,0, 1,64'h4, 1,1,32'hAAAA5555, 64'h0));
        #1;
        chk("mid_pre_valid", 64'(bus.mem_req_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("midrst");
        @(negedge clk);
        @(negedge clk);
        idle();
        #1;
        rst_n = 1'b1;
        step("rst0", v(1,0,32'h0,0,64'h0,1, 0,64'h0, 0,1,32'h0,64'h0));
        step("rst1", v(0,0,32'h0,0,64'h0,1, 1,64'h0, 0,0,32'h0,64'h0));
        step("rst2", v(0,0,32'h0,0,64'h0,1, 1,64'h0, 0,0,32'h0,64'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
